dec_frame_rx: RTL

DEC_FRAME_RX -- requirements
Module: dec_frame_rx

---
 rtl/dec_pkg.sv | 20 ++
 rtl/dec_sync_fifo.sv | 64 ++++++
 rtl/dec_frame_rx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared definitions for the serial decimator frame receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default frame width and FIFO depth, receiver state encoding,
// saturating 8-bit increment used by the abort counter.
package dec_pkg;

    localparam int DEC_DATA_W     = 22;
    localparam int DEC_FIFO_DEPTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dec_sync_fifo.sv
// Single-clock FIFO with registered occupancy count and first-word fall-through head.
// Latency: a word pushed into an empty FIFO is visible at pop_dat on the next cycle.
// Backpressure: push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
// Ports: clk/rst (sync, active-high); push/push_dat write side; pop/pop_dat read side
// (pop_dat is zero while empty); full, empty, level (0..DEPTH) status.
module dec_sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle;
    // the write lands in the slot being vacated.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dec_frame_rx.sv
// Deserialises MSB-first frames delimited by a sync pulse and queues completed words.
// Latency: completed word is at m_data_o/m_valid_o one cycle after its LSB (empty FIFO).
// Backpressure: valid/ready pop; words arriving to a full FIFO without a pop are dropped and flag ovf_o.
// Ports: clk, rst (sync, active-high); data_i/frame_sync_i serial input; m_data_o/m_valid_o/m_ready_i
// output stream; level_o occupancy; ovf_o sticky overflow with ovf_clr_i; frame_err_o aborted-frame count.
module dec_frame_rx
    import dec_pkg::*;
#(
    parameter int DATA_W     = DEC_DATA_W,
    parameter int FIFO_DEPTH = DEC_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_i,
    input  logic                          frame_sync_i,
    output logic signed [DATA_W-1:0]      m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          ovf_o,
    input  logic                          ovf_clr_i,
    output logic [7:0]                    frame_err_o
);

    localparam int CW = $clog2(DATA_W);

    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    // Holds the first DATA_W-1 bits; the LSB is taken straight from data_i.
    logic [DATA_W-2:0] sr_q, sr_d;
    logic              push;
    logic              abort;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] fifo_dat;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_acc;

    assign word = {sr_q, data_i};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        push    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_sync_i) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CW'(1);
                    sr_d    = '0;
                    sr_d[0] = data_i;
                end
            end
            ST_SHIFT: begin
                if (frame_sync_i) begin
                    // Sync always wins, even on the LSB cycle: restart on this bit.
                    abort   = 1'b1;
                    cnt_d   = CW'(1);
                    sr_d    = '0;
                    sr_d[0] = data_i;
                end else if (cnt_q == CW'(DATA_W - 1)) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    sr_d    = sr_q << 1;
                    sr_d[0] = data_i;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    assign pop_acc = m_valid_o && m_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_o       <= 1'b0;
            frame_err_o <= '0;
        end else begin
            // A new overflow outranks a clear in the same cycle.
            if (push && fifo_full && !pop_acc) begin
                ovf_o <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_o <= 1'b0;
            end
            if (abort) begin
                frame_err_o <= sat_inc8(frame_err_o);
            end
        end
    end

    dec_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (word),
        .pop      (m_ready_i),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level_o)
    );

    assign m_valid_o = !fifo_empty;
    assign m_data_o  = fifo_dat;

endmodule
